// File: rtl/lu_pipe_acc.sv
// WIDTH-bit 8-op logic unit, two-stage valid/ready pipeline with accumulator, zero/parity flags and op counter.
// Latency 2 cycles (accept edge k -> out_valid at edge k+1); S1 fills and in_ready drops while S2 is stalled.
module lu_pipe_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic             acc_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] saida,
    output logic             zero,
    output logic             paridade,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_use_acc_q, s1_use_acc_d;
    logic             s1_acc_load_q, s1_acc_load_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic             zero_q, zero_d;
    logic             par_q, par_d;

    logic [WIDTH-1:0] acc_reg_q, acc_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_free, s1_move, accept, out_hs;
    logic [WIDTH-1:0] opnd_b, result;

    assign s2_free  = !s2_v_q || out_ready;
    assign s1_move  = s1_v_q && s2_free;
    assign in_ready = rst_n && (!s1_v_q || s2_free);
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_v_q && out_ready;

    // Accumulator is only read here, at the transfer, so a chained op always sees its predecessor's write.
    assign opnd_b = s1_use_acc_q ? acc_reg_q : s1_b_q;

    always_comb begin
        result = '0;
        case (s1_op_q)
            3'b000:  result = s1_a_q & opnd_b;
            3'b001:  result = ~(s1_a_q & opnd_b);
            3'b010:  result = s1_a_q | opnd_b;
            3'b011:  result = ~(s1_a_q | opnd_b);
            3'b100:  result = s1_a_q ^ opnd_b;
            3'b101:  result = ~(s1_a_q ^ opnd_b);
            3'b110:  result = ~s1_a_q;
            default: result = opnd_b;
        endcase
    end

    always_comb begin
        s1_v_d        = s1_v_q;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_op_d       = s1_op_q;
        s1_use_acc_d  = s1_use_acc_q;
        s1_acc_load_d = s1_acc_load_q;
        s2_v_d        = s2_v_q;
        saida_d       = saida_q;
        zero_d        = zero_q;
        par_d         = par_q;
        acc_reg_d     = acc_reg_q;
        cnt_d         = cnt_q;

        if (accept) begin
            s1_v_d        = 1'b1;
            s1_a_d        = a;
            s1_b_d        = b;
            s1_op_d       = op;
            s1_use_acc_d  = use_acc;
            s1_acc_load_d = acc_load;
        end else if (s1_move) begin
            s1_v_d = 1'b0;
        end

        if (s1_move) begin
            s2_v_d  = 1'b1;
            saida_d = result;
            zero_d  = (result == '0);
            par_d   = ^result;
            if (s1_acc_load_q) begin
                acc_reg_d = result;
            end
        end else if (out_hs) begin
            s2_v_d = 1'b0;
        end

        if (out_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q        <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_op_q       <= '0;
            s1_use_acc_q  <= 1'b0;
            s1_acc_load_q <= 1'b0;
            s2_v_q        <= 1'b0;
            saida_q       <= '0;
            zero_q        <= 1'b0;
            par_q         <= 1'b0;
            acc_reg_q     <= '0;
            cnt_q         <= '0;
        end else begin
            s1_v_q        <= s1_v_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_op_q       <= s1_op_d;
            s1_use_acc_q  <= s1_use_acc_d;
            s1_acc_load_q <= s1_acc_load_d;
            s2_v_q        <= s2_v_d;
            saida_q       <= saida_d;
            zero_q        <= zero_d;
            par_q         <= par_d;
            acc_reg_q     <= acc_reg_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign saida     = saida_q;
    assign zero      = zero_q;
    assign paridade  = par_q;
    assign acc_q     = acc_reg_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_lu_pipe_acc.sv
// Bench for lu_pipe_acc: directed scenarios plus random traffic against a transaction-level queue model.
module tb_lu_pipe_acc;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    op = '0;
    logic          use_acc = 1'b0;
    logic          acc_load = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  saida;
    logic          zero;
    logic          paridade;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] op_count;

    lu_pipe_acc #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_load(acc_load),
        .out_valid(out_valid), .out_ready(out_ready),
        .saida(saida), .zero(zero), .paridade(paridade),
        .acc_q(acc_q), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] acc_after;
        int           acc_edge;
    } exp_t;

    exp_t         q[$];
    logic [9:0]   log_q[$];
    logic [W-1:0] macc = '0;
    int           cyc = 0;
    int           hs = 0;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return ~(x & y);
            3'd2:    return x | y;
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return y;
        endcase
    endfunction

    // One clock cycle: drive, check against model, update model, advance past the edge.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] iop, input logic iu, input logic il,
                        input logic ordy, output logic took);
        logic exp_ir, exp_ov;
        logic [W-1:0] r;
        in_valid = iv; a = ia; b = ib; op = iop; use_acc = iu; acc_load = il; out_ready = ordy;
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (q[0].acc_edge < cyc);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("saida", 32'(saida), 32'(q[0].res));
            chk("zero", 32'(zero), 32'(q[0].res == '0));
            chk("paridade", 32'(paridade), 32'(^q[0].res));
            chk("acc_q", 32'(acc_q), 32'(q[0].acc_after));
        end
        took = iv && exp_ir;
        if (exp_ov && ordy) begin
            log_q.push_back({zero, paridade, saida});
            void'(q.pop_front());
            hs++;
        end
        if (took) begin
            r = ref_op(iop, ia, iu ? macc : ib);
            if (il) macc = r;
            q.push_back('{r, macc, cyc + 1});
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("op_count", 32'(op_count), 32'(hs % (1 << CW)));
    endtask

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop,
                        input logic iu, input logic il, input logic ordy);
        logic took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) step(1'b1, ia, ib, iop, iu, il, ordy, took);
        if (!took) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic took;
        for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1, took);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        q.delete();
        macc = '0;
        hs = 0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_acc_q", 32'(acc_q), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_saida", 32'(saida), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_paridade", 32'(paridade), 32'd0);
        chk("rst_in_ready_hold", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [8];
        logic took;
        t1 = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'h3C};

        #2;
        do_reset();

        // Every opcode back-to-back
        log_q.delete();
        for (int i = 0; i < 8; i++) send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0, 1'b1);
        drain();
        chk("t1_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk("t1_saida", 32'(log_q[i][7:0]), 32'(t1[i]));
            chk("t1_flags", 32'(log_q[i][9:8]), 32'd0);
        end

        // Backpressure: two fill the pipe, third waits
        do_reset();
        log_q.delete();
        send(8'h11, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 8'h0F, 3'd4, 1'b0, 1'b0, 1'b0, took);
        chk("t2_held_saida", 32'(saida), 32'h33);
        send(8'h55, 8'h0F, 3'd4, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t2_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("t2_r0", 32'(log_q[0][7:0]), 32'h33);
            chk("t2_r1", 32'(log_q[1][7:0]), 32'hF0);
            chk("t2_r2", 32'(log_q[2][7:0]), 32'h5A);
        end
        chk("t2_op_count", 32'(op_count), 32'd3);

        // Accumulator chain
        log_q.delete();
        send(8'h00, 8'hA5, 3'd7, 1'b0, 1'b1, 1'b1);
        send(8'hFF, 8'h00, 3'd4, 1'b1, 1'b1, 1'b1);
        send(8'h0F, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b1);
        drain();
        chk("t3_acc", 32'(acc_q), 32'h5A);
        if (log_q.size() == 3) begin
            chk("t3_r0", 32'(log_q[0][7:0]), 32'hA5);
            chk("t3_r1", 32'(log_q[1][7:0]), 32'h5A);
            chk("t3_r2", 32'(log_q[2][7:0]), 32'h0A);
        end else chk("t3_count", 32'(log_q.size()), 32'd3);

        // Zero and parity flags
        log_q.delete();
        send(8'h77, 8'h77, 3'd4, 1'b0, 1'b0, 1'b1);
        send(8'h07, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
        drain();
        if (log_q.size() == 2) begin
            chk("t4_xor", 32'(log_q[0]), 32'h200);
            chk("t4_and", 32'(log_q[1]), 32'h107);
        end else chk("t4_count", 32'(log_q.size()), 32'd2);

        // Reset with work in flight and a loaded accumulator
        send(8'h00, 8'hA5, 3'd7, 1'b0, 1'b1, 1'b1);
        drain();
        chk("t5_acc_pre", 32'(acc_q), 32'hA5);
        send(8'h01, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0);
        send(8'h03, 8'h04, 3'd2, 1'b0, 1'b0, 1'b0);
        do_reset();
        log_q.delete();
        send(8'hC3, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        drain();
        chk("t5_after", 32'(log_q.size() == 1 ? log_q[0][7:0] : 8'h00), 32'hC3);

        // Counter wrap with a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) send(8'(i), 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("t6_wrap", 32'(op_count), 32'd1);

        // Random traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, took);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lu_pipe_acc.md
Name: lu_pipe_acc

Overview:
- Parametrised successor to the single-bit OR/NOR logic unit: WIDTH-bit, 8-operation logic unit with a 3-bit opcode.
- Two-stage valid/ready pipeline with an internal accumulator usable as operand B and as a result sink.
- Adds zero/parity flags and a completed-operation counter.
- Sits between an operand source and a result consumer in the datapath exercises; both sides use valid/ready backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand set presented
in_ready  output  1  block can accept operand set
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select
use_acc  input  1  1: operand B replaced by accumulator
acc_load  input  1  1: result of this op written to accumulator
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
saida  output  WIDTH  result
zero  output  1  saida == 0
paridade  output  1  XOR-reduction of saida
acc_q  output  WIDTH  current accumulator value
op_count  output  CNT_W  results consumed since reset, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-low, sampled on the rising edge of clk while rst_n=0.
- Reset: S1/S2 valid=0, saida=0, zero=0, paridade=0, acc_q=0, op_count=0, out_valid=0. in_ready is forced 0 while rst_n=0.
- Opcodes (bitwise on WIDTH bits):
  - 000 AND, 001 NAND, 010 OR, 011 NOR
  - 100 XOR, 101 XNOR, 110 NOT a, 111 pass B
- Operand B is acc_q when use_acc=1 for that transaction, otherwise b.
- Pipeline states:
  - Stage S1 registers a, b, op, use_acc, acc_load.
  - Stage S2 registers saida, zero, paridade.
  - S2 computes from S1 contents on transfer.
- Stall and acceptance:
  - s2_free = !s2_v || out_ready.
  - s1_move = s1_v && s2_free.
  - in_ready = rst_n && (!s1_v || s2_free).
- Acceptance on an edge with in_valid && in_ready: S1 loads; S1 holds otherwise.
- Transfer S1->S2 on s1_move. Output handshake (out_valid && out_ready) clears s2_v unless a transfer refills it on the same edge.
- Latency and throughput:
  - Accept at edge k gives out_valid at edge k+1, 2 cycles from in_valid.
  - Throughput is 1 op/cycle with out_ready held 1.
- Accumulator:
  - Read and written only at the S1->S2 transfer edge.
  - If the transferring op has acc_load=1, acc_q <= computed result on that edge.
  - The next op's use_acc sees the updated value; no hazard by construction.
- Backpressure:
  - out_valid=1 and out_ready=0 hold saida/zero/paridade stable.
  - S1 then fills and in_ready drops, so at most 2 ops are in flight.
- op_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Simultaneous events: accept, transfer and output handshake all on one edge are legal; no loss, no duplication.
- Reset mid-operation discards both stages and clears accumulator and counter. out_valid goes 0 on the reset edge.
- Inputs are ignored whenever in_ready=0.

Test Plan:
1. WIDTH=8, a=8'hF0, b=8'h3C, out_ready=1, op 000..111 back-to-back.
   - Required saida: 30, CF, FC, 03, CC, 33, 0F, 3C.
   - Required zero flags: all 0.
   - Required paridade: 0,0,0,0,0,0,0,0.
   - One result per cycle after 2-cycle latency.
2. Backpressure: out_ready=0 while sending 3 ops.
   - in_ready drops after 2 accepts.
   - saida holds the first result.
   - Raising out_ready drains all 3 results in order; op_count=3.
3. Accumulator chain:
   - Send op=111, b=8'hA5, acc_load=1: acc_q=A5.
   - Then op=100, a=8'hFF, use_acc=1, acc_load=1: saida=5A, acc_q=5A.
   - Then op=000, a=8'h0F, use_acc=1: saida=0A.
4. Zero/parity: op=100, a=b=8'h77 -> saida=00, zero=1, paridade=0. op=000, a=8'h07, b=8'hFF -> saida=07, paridade=1.
5. Reset mid-operation: 2 ops in flight, acc_q=A5, rst_n=0 for one edge.
   - out_valid=0, acc_q=0, op_count=0, in_ready=0 during reset.
   - The next op after reset completes normally.
6. Wrap: CNT_W=4, 17 output handshakes -> op_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
